aadd_accum_ctrl: RTL and testbench

Sequencer that accumulates a stream of signed 32-bit operands through one shared aadd32 instance. It maintains an exact running sum and an approximate running sum side by side. The adder is time-multiplexed: one cycle feeds the exact accumulator, the next feeds the approximate accumulator. It sits between a vector source (e.g. the product stream of a qmac lane) and the verification/statistics logic that compares exact against approximate reduction.

---
 rtl/aadd_accum_ctrl_pkg.sv | 24 ++
 rtl/aadd_accum_ctrl_aadd32.sv | 30 +++
 rtl/aadd_accum_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_aadd_accum_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/aadd_accum_ctrl_pkg.sv
// Shared types and constants for the approximate-adder accumulation controller.
package aadd_pkg;

    // Datapath width of the shared aadd32 adder and of every accumulator.
    localparam int DATA_W        = 32;

    // Default width of the vector-length field.
    localparam int LEN_W_DEFAULT = 16;

    // Sequencer states. The adder is time-multiplexed between ADD_EX and ADD_AP.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ADD_EX = 3'd2,
        ADD_AP = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Unsigned magnitude of a two's complement value; -2^31 maps to 0x80000000.
    function automatic logic [DATA_W-1:0] abs_u(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/aadd_accum_ctrl_aadd32.sv
// aadd32: 32-bit adder producing an exact sum and a lower-part-OR approximate sum.
// The low DROP bits of the approximate result are the bitwise OR of the operands
// and generate no carry into the upper part; the upper bits are added exactly.
// All arithmetic wraps at 32 bits.
module aadd32 #(
    parameter int DROP = 0
) (
    input  logic signed [31:0] x,
    input  logic signed [31:0] y,
    output logic signed [31:0] exact,
    output logic signed [31:0] approx
);

    // Mask of the approximated low bits; DROP=0 gives an all-zero mask (exact adder).
    localparam logic [31:0] LO_MASK = (DROP >= 32) ? 32'hFFFF_FFFF
                                                   : ((32'd1 << DROP) - 32'd1);

    // Lower-part OR addition: no carry crosses the LO_MASK boundary.
    function automatic logic [31:0] loa_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] w_lo;
        logic [31:0] w_hi;
        w_lo = (a | b) & LO_MASK;
        w_hi = (a & ~LO_MASK) + (b & ~LO_MASK);
        return w_hi | w_lo;
    endfunction

    assign exact  = x + y;
    assign approx = $signed(loa_add($unsigned(x), $unsigned(y)));

endmodule

// File: rtl/aadd_accum_ctrl.sv
// aadd_accum_ctrl: accumulates a stream of signed 32-bit operands through one
// shared aadd32, keeping an exact and an approximate running sum side by side.
// Each element costs three cycles: LOAD (operand handshake), ADD_EX (adder
// feeds the exact accumulator), ADD_AP (adder feeds the approximate one).
// Optional feature macro: AADD_ERRSTAT_EN enables tracking of the largest
// per-step |exact - approx| on max_err; without it max_err is tied to zero.
module aadd_accum_ctrl
    import aadd_pkg::*;
#(
    parameter int DROP  = 0,
    parameter int LEN_W = LEN_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [LEN_W-1:0]         len,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] exact_sum,
    output logic signed [DATA_W-1:0] approx_sum,
    output logic signed [DATA_W-1:0] err,
    output logic [DATA_W-1:0]        max_err,
    output logic                     busy
);

    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_ZERO = '0;

    state_t                     r_state;
    state_t                     w_next;
    logic [LEN_W-1:0]           r_len;
    logic [LEN_W-1:0]           r_count;
    logic signed [DATA_W-1:0]   r_exact;
    logic signed [DATA_W-1:0]   r_approx;
    logic signed [DATA_W-1:0]   r_opnd;

    logic signed [DATA_W-1:0]   w_x;
    logic signed [DATA_W-1:0]   w_y;
    logic signed [DATA_W-1:0]   w_sum_exact;
    logic signed [DATA_W-1:0]   w_sum_approx;
    logic                       w_start_acc;
    logic                       w_load_hs;
    logic                       w_last;

    // A start is honoured only in IDLE; everywhere else it is ignored.
    assign w_start_acc = (r_state == IDLE) && start;
    assign w_load_hs   = (r_state == LOAD) && in_valid;
    assign w_last      = ((r_count + LEN_ONE) == r_len);

    // Shared adder, time-multiplexed between the two accumulators.
    aadd32 #(
        .DROP (DROP)
    ) u_aadd32 (
        .x      (w_x),
        .y      (w_y),
        .exact  (w_sum_exact),
        .approx (w_sum_approx)
    );

    // Operand mux: select the accumulator owning this cycle; idle the adder otherwise.
    always_comb begin
        w_x = '0;
        w_y = '0;
        case (r_state)
            ADD_EX: begin
                w_x = r_exact;
                w_y = r_opnd;
            end
            ADD_AP: begin
                w_x = r_approx;
                w_y = r_opnd;
            end
            default: begin
                w_x = '0;
                w_y = '0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (len == LEN_ZERO) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    w_next = ADD_EX;
                end
            end
            ADD_EX: begin
                w_next = ADD_AP;
            end
            ADD_AP: begin
                w_next = w_last ? DONE : LOAD;
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            IDLE:    busy      = 1'b0;
            LOAD:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Length latch, operand register, element count and both accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len    <= '0;
            r_count  <= '0;
            r_exact  <= '0;
            r_approx <= '0;
            r_opnd   <= '0;
        end else begin
            if (w_start_acc) begin
                r_len    <= len;
                r_count  <= '0;
                r_exact  <= '0;
                r_approx <= '0;
            end
            if (w_load_hs) begin
                r_opnd <= in_data;
            end
            if (r_state == ADD_EX) begin
                r_exact <= w_sum_exact;
            end
            if (r_state == ADD_AP) begin
                r_approx <= w_sum_approx;
                r_count  <= r_count + LEN_ONE;
            end
        end
    end

    // Accumulators are visible live; they only hold still once DONE is reached.
    assign exact_sum  = r_exact;
    assign approx_sum = r_approx;
    assign err        = r_exact - r_approx;

`ifdef AADD_ERRSTAT_EN
    logic [DATA_W-1:0]        r_max_err;
    logic signed [DATA_W-1:0] w_step_d;
    logic [DATA_W-1:0]        w_step_mag;

    // In ADD_AP the exact accumulator is already updated; pair it with the new approx value.
    assign w_step_d   = r_exact - w_sum_approx;
    assign w_step_mag = abs_u(w_step_d);

    // Running maximum of the per-step error magnitude, cleared on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max_err <= '0;
        end else if (w_start_acc) begin
            r_max_err <= '0;
        end else if ((r_state == ADD_AP) && (w_step_mag > r_max_err)) begin
            r_max_err <= w_step_mag;
        end
    end

    assign max_err = r_max_err;
`else
    assign max_err = '0;
`endif

endmodule

// File: tb/tb_aadd_accum_ctrl.sv
// Directed bench for aadd_accum_ctrl: two instances (DROP=0 and DROP=4) share
// all stimulus so exact and approximate behaviour are checked together.
module tb_aadd_accum_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] len;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready0, out_valid0, busy0;
    logic [31:0] exact0, approx0, err0, maxerr0;
    logic        in_ready4, out_valid4, busy4;
    logic [31:0] exact4, approx4, err4, maxerr4;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] vec [8];

`ifdef AADD_ERRSTAT_EN
    localparam bit ERRSTAT = 1'b1;
`else
    localparam bit ERRSTAT = 1'b0;
`endif

    always #5 clk = ~clk;

    aadd_accum_ctrl #(.DROP(0), .LEN_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready),
        .exact_sum(exact0), .approx_sum(approx0), .err(err0),
        .max_err(maxerr0), .busy(busy0)
    );

    aadd_accum_ctrl #(.DROP(4), .LEN_W(16)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready),
        .exact_sum(exact4), .approx_sum(approx4), .err(err4),
        .max_err(maxerr4), .busy(busy4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Start a run of length l over vec[], feed operands on handshakes, return cycles to out_valid.
    task automatic run_vec(input logic [15:0] l, input bit toggle, input bit poke, output int lat);
        int  idx;
        int  cyc;
        bit  hs;
        idx = 0;
        cyc = 0;
        @(posedge clk); #1;
        start    = 1'b1;
        len      = l;
        in_data  = vec[0];
        in_valid = 1'b1;
        do begin
            hs = in_valid && in_ready0;
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            len   = 16'd1;
            if (hs && idx < 7) begin
                idx++;
                in_data = vec[idx];
            end
            if (toggle) in_valid = ~in_valid;
            if (poke && (cyc % 4 == 2)) start = 1'b1;
        end while (!out_valid0 && cyc < 300);
        start = 1'b0;
        lat   = cyc;
        if (!out_valid0) check("timeout_out_valid", {31'd0, out_valid0}, 32'd1);
    endtask

    // Hold out_ready low for 'hold' cycles checking stability, then handshake with a start pulse.
    task automatic drain(input int hold);
        logic [31:0] ex_s, ap_s, er_s;
        ex_s = exact0;
        ap_s = approx4;
        er_s = err4;
        for (int i = 0; i < hold; i++) begin
            start = (i == 1);
            @(posedge clk); #1;
            check("hold_valid", {31'd0, out_valid0}, 32'd1);
            check("hold_exact", exact0, ex_s);
            check("hold_approx4", approx4, ap_s);
            check("hold_err4", err4, er_s);
        end
        out_ready = 1'b1;
        start     = 1'b1;
        len       = 16'd2;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drain_valid", {31'd0, out_valid0}, 32'd0);
        check("drain_busy", {31'd0, busy0}, 32'd0);
        start = 1'b0;
    endtask

    initial begin
        int lat;
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) vec[i] = '0;
        #12;
        check("rst_exact", exact0, 32'd0);
        check("rst_approx", approx4, 32'd0);
        check("rst_err", err4, 32'd0);
        check("rst_maxerr", maxerr4, 32'd0);
        check("rst_in_ready", {31'd0, in_ready0}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid0}, 32'd0);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic run 1,2,3,4.
        vec[0] = 32'd1; vec[1] = 32'd2; vec[2] = 32'd3; vec[3] = 32'd4;
        run_vec(16'd4, 1'b0, 1'b0, lat);
        check("t1_latency", lat, 32'd13);
        check("t1_exact0", exact0, 32'd10);
        check("t1_approx0", approx0, 32'd10);
        check("t1_err0", err0, 32'd0);
        check("t1_maxerr0", maxerr0, 32'd0);
        check("t1_exact4", exact4, 32'd10);
        check("t1_approx4", approx4, 32'd7);
        check("t1_err4", err4, 32'd3);
        check("t1_maxerr4", maxerr4, ERRSTAT ? 32'd3 : 32'd0);
        drain(0);

        // Signed wrap at the top of the range.
        vec[0] = 32'h7FFF_FFFF; vec[1] = 32'd1;
        run_vec(16'd2, 1'b0, 1'b0, lat);
        check("t2_latency", lat, 32'd7);
        check("t2_exact0", exact0, 32'h8000_0000);
        check("t2_err0", err0, 32'd0);
        check("t2_approx4", approx4, 32'h7FFF_FFFF);
        drain(0);

        // Zero-length vector goes straight to DONE and holds there.
        run_vec(16'd0, 1'b0, 1'b0, lat);
        check("t3_latency", lat, 32'd1);
        check("t3_exact0", exact0, 32'd0);
        check("t3_approx0", approx0, 32'd0);
        drain(5);

        // Approximation visible with DROP=4.
        vec[0] = 32'd15; vec[1] = 32'd15; vec[2] = 32'd15;
        run_vec(16'd3, 1'b0, 1'b0, lat);
        check("t4_exact4", exact4, 32'd45);
        check("t4_approx4", approx4, 32'd15);
        check("t4_err4", err4, 32'd30);
        check("t4_maxerr4", maxerr4, ERRSTAT ? 32'd30 : 32'd0);
        check("t4_approx0", approx0, 32'd45);
        drain(0);

        // Input backpressure, ignored start pulses, delayed out_ready.
        vec[0] = 32'd1; vec[1] = 32'd2; vec[2] = 32'd3; vec[3] = 32'd4;
        run_vec(16'd4, 1'b1, 1'b1, lat);
        in_valid = 1'b1;
        check("t5_stalled", {31'd0, (lat > 13)}, 32'd1);
        check("t5_exact0", exact0, 32'd10);
        check("t5_approx0", approx0, 32'd10);
        check("t5_approx4", approx4, 32'd7);
        check("t5_err4", err4, 32'd3);
        check("t5_maxerr4", maxerr4, ERRSTAT ? 32'd3 : 32'd0);
        drain(3);

        // Reset during ADD_EX of the second element.
        @(posedge clk); #1;
        start = 1'b1; len = 16'd3; in_valid = 1'b1; in_data = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        in_data = 32'd20;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t6_pre_exact", exact0, 32'd10);
        check("t6_pre_busy", {31'd0, busy0}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_exact", exact0, 32'd0);
        check("t6_rst_approx", approx4, 32'd0);
        check("t6_rst_err", err4, 32'd0);
        check("t6_rst_busy", {31'd0, busy0}, 32'd0);
        check("t6_rst_in_ready", {31'd0, in_ready0}, 32'd0);
        check("t6_rst_out_valid", {31'd0, out_valid0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        vec[0] = 32'hFFFF_FFFB;
        run_vec(16'd1, 1'b0, 1'b0, lat);
        check("t6_latency", lat, 32'd4);
        check("t6_exact0", exact0, 32'hFFFF_FFFB);
        check("t6_err0", err0, 32'd0);
        check("t6_approx4", approx4, 32'hFFFF_FFFB);
        drain(0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
